hazard_unit: RTL

Hazard control for the five-stage MIPS pipeline. It sits beside the IF/ID and ID/EX pipeline registers and reads the ID/EX outputs back, together with EX/MEM, MEM/WB and the decoded IF/ID instruction. From these it produces stall, bubble and flush controls for PC, IF/ID and ID/EX, plus the EX-stage forwarding selects. It also keeps a registered hazard state, saturating stall and flush statistics, and a sticky runaway-stall error flag.

---
 rtl/hazard_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use/branch stalls, taken-branch flush, EX forwarding selects, plus
// registered state/statistics. Controls are combinational (0 cycles); stats update one posedge later.
module hazard_unit #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs_addr_ID,
  input  logic [4:0]       Rt_addr_ID,
  input  logic             uses_rt_ID,
  input  logic             branch_ID,
  input  logic             branch_taken,
  input  logic             MemRead_IE,
  input  logic             write_IE,
  input  logic [4:0]       Rs_addr_IE,
  input  logic [4:0]       Rt_addr_IE,
  input  logic [4:0]       dst_addr_IE,
  input  logic             MemRead_EM,
  input  logic             write_EM,
  input  logic [4:0]       dst_addr_EM,
  input  logic             write_MW,
  input  logic [4:0]       dst_addr_MW,
  output logic             PCWrite,
  output logic             IFID_write,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic [1:0]       ForwardA,
  output logic [1:0]       ForwardB,
  output logic [1:0]       hz_state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             hazard_err
);

  typedef enum logic [1:0] {
    HZ_RUN      = 2'd0,
    HZ_STALL_LD = 2'd1,
    HZ_STALL_BR = 2'd2,
    HZ_FLUSH    = 2'd3
  } hz_state_e;

  localparam int RUN_W = $clog2(MAX_STALL + 2);

  hz_state_e        state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [RUN_W-1:0] run_cnt_q, run_cnt_d;
  logic             err_q, err_d;

  logic ld_use, br_ex, br_mem, stall, flush;

  // Register 0 is hardwired, so it can never be a real dependency.
  function automatic logic src_match(input logic [4:0] x, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic use_rt);
    return (x != 5'd0) && ((x == rs) || (use_rt && (x == rt)));
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                         input logic wr_em, input logic [4:0] dst_em,
                                         input logic wr_mw, input logic [4:0] dst_mw);
    if (wr_em && (dst_em != 5'd0) && (dst_em == src)) return 2'b10;
    if (wr_mw && (dst_mw != 5'd0) && (dst_mw == src)) return 2'b01;
    return 2'b00;
  endfunction

  always_comb begin
    ld_use = MemRead_IE && src_match(Rt_addr_IE, Rs_addr_ID, Rt_addr_ID, uses_rt_ID);
    br_ex  = branch_ID && write_IE && src_match(dst_addr_IE, Rs_addr_ID, Rt_addr_ID, uses_rt_ID);
    br_mem = branch_ID && MemRead_EM && src_match(dst_addr_EM, Rs_addr_ID, Rt_addr_ID, uses_rt_ID);
    stall  = ld_use | br_ex | br_mem;
    // An unresolved branch (operands pending) must not redirect fetch.
    flush  = branch_ID && branch_taken && !stall;
  end

  assign PCWrite     = !stall;
  assign IFID_write  = !stall;
  assign IDEX_bubble = stall;
  assign IFID_flush  = flush;
  assign ForwardA    = fwd_sel(Rs_addr_IE, write_EM, dst_addr_EM, write_MW, dst_addr_MW);
  assign ForwardB    = fwd_sel(Rt_addr_IE, write_EM, dst_addr_EM, write_MW, dst_addr_MW);

  always_comb begin
    state_d     = HZ_RUN;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    run_cnt_d   = run_cnt_q;
    err_d       = err_q;

    if (ld_use)               state_d = HZ_STALL_LD;
    else if (br_ex || br_mem) state_d = HZ_STALL_BR;
    else if (flush)           state_d = HZ_FLUSH;

    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);

    if (!stall)
      run_cnt_d = '0;
    else if (run_cnt_q != RUN_W'(MAX_STALL + 1))
      run_cnt_d = run_cnt_q + RUN_W'(1);

    if (stall && (run_cnt_q == RUN_W'(MAX_STALL))) err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HZ_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      run_cnt_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      run_cnt_q   <= run_cnt_d;
      err_q       <= err_d;
    end
  end

  assign hz_state    = state_q;
  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
  assign hazard_err  = err_q;

endmodule
